// File: rtl/msrv32_csr_bank.sv
// msrv32_csr_bank: machine-mode CSR bank (RMW, trap/MRET, irq sync, counters); optional mtimecmp via CSR_TIMECMP_EN
module msrv32_csr_bank #(
  parameter int          CNT_W       = 64,
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [31:0] RESET_MTVEC = 32'h0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        wr_en_in,
  input  logic [11:0] csr_addr_in,
  input  logic [2:0]  csr_op_in,
  input  logic [4:0]  csr_uimm_in,
  input  logic [31:0] csr_data_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] iadder_in,
  input  logic [2:0]  irq_in,
  input  logic        trap_in,
  input  logic        i_or_e_in,
  input  logic [3:0]  cause_in,
  input  logic        mret_in,
  input  logic        instret_inc_in,
  input  logic        misaligned_exception_in,
  input  logic [63:0] real_time_in,
  output logic [31:0] csr_data_out,
  output logic        illegal_csr_out,
  output logic        irq_req_out,
  output logic [3:0]  irq_cause_out,
  output logic [31:0] epc_out,
  output logic [31:0] trap_address_out
);
  logic                            r_mie, r_mpie;
  logic [2:0]                      r_mie_en;
  logic [31:0]                     r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [CNT_W-1:0]                r_mcycle, r_minstret;
  logic [SYNC_STAGES-1:0][2:0]     r_sync;
  logic                            w_mtip, w_impl, w_op_ok, w_wr_try, w_ro, w_we, w_vec;
  logic [2:0]                      w_mip, w_pend;
  logic [31:0]                     w_src, w_new, w_rdata, w_mstatus, w_mie32, w_mip32, w_base, w_tgt;
  logic [63:0]                     w_cyc, w_ins, w_cyc_nxt, w_ins_nxt;
`ifdef CSR_TIMECMP_EN
  logic [63:0]                     r_mtimecmp;
  logic                            r_mtip;
  // mtimecmp is written by halves; the timer interrupt is a registered compare against mtime
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      r_mtimecmp <= '1;
      r_mtip     <= 1'b0;
    end else begin
      if (w_we && csr_addr_in == 12'h7C0) r_mtimecmp[31:0]  <= w_new;
      if (w_we && csr_addr_in == 12'h7C1) r_mtimecmp[63:32] <= w_new;
      r_mtip <= real_time_in >= r_mtimecmp;
    end
  assign w_mtip = r_mtip;
`else
  assign w_mtip = r_sync[SYNC_STAGES-1][1];
`endif
  assign w_mip     = {r_sync[SYNC_STAGES-1][2], w_mtip, r_sync[SYNC_STAGES-1][0]};
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
  assign w_mie32   = {20'b0, r_mie_en[2], 3'b0, r_mie_en[1], 3'b0, r_mie_en[0], 3'b0};
  assign w_mip32   = {20'b0, w_mip[2], 3'b0, w_mip[1], 3'b0, w_mip[0], 3'b0};
  assign w_cyc     = 64'(r_mcycle);
  assign w_ins     = 64'(r_minstret);
  // address decode: read data and whether the address is implemented at all
  always_comb begin
    w_rdata = '0;
    w_impl  = 1'b1;
    case (csr_addr_in)
      12'h300: w_rdata = w_mstatus;
      12'h304: w_rdata = w_mie32;
      12'h305: w_rdata = r_mtvec;
      12'h340: w_rdata = r_mscratch;
      12'h341: w_rdata = r_mepc;
      12'h342: w_rdata = r_mcause;
      12'h343: w_rdata = r_mtval;
      12'h344: w_rdata = w_mip32;
      12'hB00, 12'hC00: w_rdata = w_cyc[31:0];
      12'hB80, 12'hC80: w_rdata = w_cyc[63:32];
      12'hB02, 12'hC02: w_rdata = w_ins[31:0];
      12'hB82, 12'hC82: w_rdata = w_ins[63:32];
      12'hC01: w_rdata = real_time_in[31:0];
      12'hC81: w_rdata = real_time_in[63:32];
      12'hF11, 12'hF12, 12'hF13, 12'hF14: w_rdata = '0;
`ifdef CSR_TIMECMP_EN
      12'h7C0: w_rdata = r_mtimecmp[31:0];
      12'h7C1: w_rdata = r_mtimecmp[63:32];
`endif
      default: w_impl = 1'b0;
    endcase
  end
  assign csr_data_out    = w_rdata;
  assign w_src           = csr_op_in[2] ? {27'b0, csr_uimm_in} : csr_data_in;
  assign w_op_ok         = |csr_op_in[1:0];
  assign w_wr_try        = csr_op_in[1:0] == 2'b01 || |w_src;
  assign w_ro            = csr_addr_in[11:10] == 2'b11 || csr_addr_in == 12'h344;
  assign illegal_csr_out = wr_en_in & (~w_op_ok | ~w_impl | (w_ro & w_wr_try));
  assign w_new           = csr_op_in[1:0] == 2'b01 ? w_src :
                           csr_op_in[1:0] == 2'b10 ? w_rdata | w_src : w_rdata & ~w_src;
  assign w_we            = wr_en_in & ~illegal_csr_out & w_wr_try & ~trap_in;
  assign w_cyc_nxt       = w_we && csr_addr_in == 12'hB00 ? {w_cyc[63:32], w_new} :
                           w_we && csr_addr_in == 12'hB80 ? {w_new, w_cyc[31:0]} : w_cyc + 64'd1;
  assign w_ins_nxt       = w_we && csr_addr_in == 12'hB02 ? {w_ins[63:32], w_new} :
                           w_we && csr_addr_in == 12'hB82 ? {w_new, w_ins[31:0]} :
                           w_ins + 64'(instret_inc_in);
  assign w_pend          = w_mip & r_mie_en;
  assign irq_req_out     = r_mie & |w_pend;
  assign irq_cause_out   = w_pend[2] ? 4'd11 : w_pend[0] ? 4'd3 : w_pend[1] ? 4'd7 : 4'd0;
  assign w_base          = {r_mtvec[31:2], 2'b00};
  assign w_vec           = VECTORED_EN && r_mtvec[1:0] == 2'b01;
  assign w_tgt           = w_vec && i_or_e_in ? w_base + {26'b0, cause_in, 2'b00} : w_base;
  // interrupt lines cross into the clock domain through a shift chain
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], irq_in};
  // counters; a CSR write to one half replaces that cycle's increment
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= w_cyc_nxt[CNT_W-1:0];
      r_minstret <= w_ins_nxt[CNT_W-1:0];
    end
  // trap entry beats MRET, which beats a CSR write to mstatus; trap also drops the write
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      r_mie            <= 1'b0;
      r_mpie           <= 1'b1;
      r_mie_en         <= '0;
      r_mtvec          <= RESET_MTVEC;
      r_mscratch       <= '0;
      r_mepc           <= '0;
      r_mcause         <= '0;
      r_mtval          <= '0;
      epc_out          <= '0;
      trap_address_out <= RESET_MTVEC;
    end else begin
      epc_out <= r_mepc;
      if (trap_in) begin
        r_mepc           <= pc_in & ~32'h3;
        r_mcause         <= {i_or_e_in, 27'b0, cause_in};
        r_mpie           <= r_mie;
        r_mie            <= 1'b0;
        r_mtval          <= misaligned_exception_in ? iadder_in : 32'h0;
        trap_address_out <= w_tgt;
      end else begin
        if (mret_in) begin
          r_mie            <= r_mpie;
          r_mpie           <= 1'b1;
          trap_address_out <= r_mepc;
        end else if (w_we && csr_addr_in == 12'h300) begin
          r_mie  <= w_new[3];
          r_mpie <= w_new[7];
        end
        if (w_we && csr_addr_in == 12'h304) r_mie_en   <= {w_new[11], w_new[7], w_new[3]};
        if (w_we && csr_addr_in == 12'h305) r_mtvec    <= {w_new[31:2], 1'b0, VECTORED_EN & w_new[0]};
        if (w_we && csr_addr_in == 12'h340) r_mscratch <= w_new;
        if (w_we && csr_addr_in == 12'h341) r_mepc     <= {w_new[31:2], 2'b00};
        if (w_we && csr_addr_in == 12'h342) r_mcause   <= w_new;
        if (w_we && csr_addr_in == 12'h343) r_mtval    <= w_new;
      end
    end
endmodule

// File: tb/tb_msrv32_csr_bank.sv
// tb_msrv32_csr_bank: directed scoreboard bench for msrv32_csr_bank (plus a CNT_W=40 instance)
module tb_msrv32_csr_bank;
  logic        clk_in = 1'b0, rst_in = 1'b1;
  logic        wr_en_in = 0, trap_in = 0, i_or_e_in = 0, mret_in = 0, instret_inc_in = 0, mis_in = 0;
  logic [11:0] csr_addr_in = 0;
  logic [2:0]  csr_op_in = 0, irq_in = 0;
  logic [4:0]  csr_uimm_in = 0;
  logic [31:0] csr_data_in = 0, pc_in = 0, iadder_in = 0;
  logic [3:0]  cause_in = 0;
  logic [63:0] real_time_in = 0;
  logic [31:0] csr_data_out, epc_out, trap_address_out, d40, e40, t40;
  logic        illegal_csr_out, irq_req_out, ill40, irq40;
  logic [3:0]  irq_cause_out, c40;
  logic [31:0] r_old, r_old40;
  logic        r_ill;
  logic [31:0] exp_q[$];
  int          n_chk = 0, n_fail = 0;
  always #5 clk_in = ~clk_in;
  msrv32_csr_bank #(.RESET_MTVEC(32'h400)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .wr_en_in(wr_en_in), .csr_addr_in(csr_addr_in),
    .csr_op_in(csr_op_in), .csr_uimm_in(csr_uimm_in), .csr_data_in(csr_data_in), .pc_in(pc_in),
    .iadder_in(iadder_in), .irq_in(irq_in), .trap_in(trap_in), .i_or_e_in(i_or_e_in),
    .cause_in(cause_in), .mret_in(mret_in), .instret_inc_in(instret_inc_in),
    .misaligned_exception_in(mis_in), .real_time_in(real_time_in), .csr_data_out(csr_data_out),
    .illegal_csr_out(illegal_csr_out), .irq_req_out(irq_req_out), .irq_cause_out(irq_cause_out),
    .epc_out(epc_out), .trap_address_out(trap_address_out));
  msrv32_csr_bank #(.CNT_W(40), .RESET_MTVEC(32'h400)) u_dut40 (
    .clk_in(clk_in), .rst_in(rst_in), .wr_en_in(wr_en_in), .csr_addr_in(csr_addr_in),
    .csr_op_in(csr_op_in), .csr_uimm_in(csr_uimm_in), .csr_data_in(csr_data_in), .pc_in(pc_in),
    .iadder_in(iadder_in), .irq_in(irq_in), .trap_in(trap_in), .i_or_e_in(i_or_e_in),
    .cause_in(cause_in), .mret_in(mret_in), .instret_inc_in(instret_inc_in),
    .misaligned_exception_in(mis_in), .real_time_in(real_time_in), .csr_data_out(d40),
    .illegal_csr_out(ill40), .irq_req_out(irq40), .irq_cause_out(c40),
    .epc_out(e40), .trap_address_out(t40));
  function automatic void push(input logic [31:0] v);
    exp_q.push_back(v);
  endfunction
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = 32'hxxxx_xxxx;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    n_chk++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask
  task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d, input logic [4:0] u);
    wr_en_in = 1; csr_op_in = op; csr_addr_in = a; csr_data_in = d; csr_uimm_in = u;
    #1 r_old = csr_data_out; r_ill = illegal_csr_out; r_old40 = d40;
    @(negedge clk_in);
    wr_en_in = 0; csr_op_in = 0; csr_data_in = 0; csr_uimm_in = 0;
  endtask
  task automatic rd(input logic [11:0] a);
    csr(3'b010, a, 32'h0, 5'h0);
  endtask
  initial begin
    repeat (2) @(negedge clk_in);
    rst_in = 0;
    push(32'h400);       rd(12'h305); check("mtvec_rst", r_old);
    push(32'h1880);      rd(12'h300); check("mstatus_rst", r_old);
    push(32'h0);         check("ill_rst", {31'b0, r_ill});
    push(32'h0);         check("epc_rst", epc_out);
    push(32'h400);       check("tgt_rst", trap_address_out);
    push(32'h0);         csr(3'b001, 12'h340, 32'hA5A5_0000, 0); check("rw340_old", r_old);
    push(32'hA5A5_0000); csr(3'b010, 12'h340, 32'h5A5A, 0);      check("rs340_old", r_old);
    push(32'hA5A5_5A5A); rd(12'h340); check("rs340_new", r_old);
    push(32'h0);         csr(3'b011, 12'hF11, 32'h0, 0); check("rc0_f11_ill", {31'b0, r_ill});
    push(32'h1);         csr(3'b001, 12'hF11, 32'h1, 0); check("rw_f11_ill", {31'b0, r_ill});
    push(32'h1);         csr(3'b000, 12'h340, 32'h1, 0); check("op000_ill", {31'b0, r_ill});
    push(32'h1);         csr(3'b110, 12'hC00, 32'h0, 5'd1); check("rsi_c00_ill", {31'b0, r_ill});
    push(32'hA5A5_5A5A); csr(3'b111, 12'h340, 32'h0, 5'h1A); check("rci_old", r_old);
    push(32'hA5A5_5A40); rd(12'h340); check("rci_new", r_old);
`ifdef CSR_TIMECMP_EN
    csr(3'b001, 12'h7C1, 32'h0, 0);
    csr(3'b001, 12'h7C0, 32'd100, 0);
    real_time_in = 64'd99;
    @(negedge clk_in);
    push(32'h0);  rd(12'h344); check("mtip_99", r_old & 32'h80);
    real_time_in = 64'd100;
    @(negedge clk_in);
    push(32'h80); rd(12'h344); check("mtip_100", r_old & 32'h80);
    real_time_in = 64'd0;
`else
    push(32'h1);  rd(12'h7C0); check("7c0_ill", {31'b0, r_ill});
`endif
    csr(3'b001, 12'h305, 32'h101, 0);
    csr(3'b010, 12'h300, 32'h8, 0);
    csr(3'b010, 12'h304, 32'h800, 0);
    irq_in = 3'b100;
    @(negedge clk_in);
    #1 push(32'h0); check("irq_1clk", {31'b0, irq_req_out});
    @(negedge clk_in);
    #1 push(32'h1); check("irq_2clk", {31'b0, irq_req_out});
    push(32'd11);   check("irq_cause", {28'b0, irq_cause_out});
    trap_in = 1; i_or_e_in = 1; cause_in = 4'd11; pc_in = 32'h303;
    @(negedge clk_in);
    trap_in = 0; i_or_e_in = 0; cause_in = 0; irq_in = 0;
    #1 push(32'h12C); check("tgt_vec", trap_address_out);
    push(32'h0);         check("irq_masked", {31'b0, irq_req_out});
    push(32'h1880);      rd(12'h300); check("mstatus_trap", r_old);
    push(32'h8000_000B); rd(12'h342); check("mcause_irq", r_old);
    push(32'h300);       rd(12'h341); check("mepc_irq", r_old);
    push(32'h300);       check("epc_out_irq", epc_out);
    csr(3'b001, 12'hB00, 32'hFFFF_FFFF, 0);
    push(32'h0); rd(12'hB80); check("hi_no_carry", r_old);
    push(32'h0); rd(12'hB00); check("lo_wrap", r_old);
    push(32'h1); rd(12'hB80); check("hi_carry", r_old);
    csr(3'b001, 12'hB80, 32'hFFFF_FFFF, 0);
    rd(12'hB80);
    push(32'hFFFF_FFFF); check("hi_w64", r_old);
    push(32'h0000_00FF); check("hi_w40", r_old40);
    csr(3'b001, 12'hB02, 32'd5, 0);
    instret_inc_in = 1;
    repeat (3) @(negedge clk_in);
    instret_inc_in = 0;
    push(32'd8);  rd(12'hC02); check("minstret_inc", r_old);
    instret_inc_in = 1;
    csr(3'b001, 12'hB02, 32'd20, 0);
    instret_inc_in = 0;
    push(32'd20); rd(12'hB02); check("minstret_wr_wins", r_old);
    csr(3'b010, 12'h300, 32'h8, 0);
    trap_in = 1; cause_in = 4'd4; mis_in = 1; iadder_in = 32'h1003; pc_in = 32'h200;
    wr_en_in = 1; csr_op_in = 3'b001; csr_addr_in = 12'h340; csr_data_in = 32'hDEAD_BEEF;
    @(negedge clk_in);
    trap_in = 0; cause_in = 0; mis_in = 0; wr_en_in = 0; csr_op_in = 0; csr_data_in = 0;
    #1 push(32'h100); check("tgt_exc", trap_address_out);
    push(32'h1003);      rd(12'h343); check("mtval_mis", r_old);
    push(32'h200);       rd(12'h341); check("mepc_mis", r_old);
    push(32'hA5A5_5A40); rd(12'h340); check("wr_dropped", r_old);
    push(32'h1880);      rd(12'h300); check("mstatus_exc", r_old);
    mret_in = 1;
    @(negedge clk_in);
    mret_in = 0;
    #1 push(32'h200); check("tgt_mret", trap_address_out);
    push(32'h200);    check("epc_out_mis", epc_out);
    push(32'h1888);   rd(12'h300); check("mstatus_mret", r_old);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
